// File: rtl/lsu_pkg.sv
// Shared types and defaults for the load/store unit: access sizes, FSM states,
// latched request control and the alignment rule.
package lsu_pkg;

  localparam int unsigned ADDR_W_DEF = 32;
  localparam int unsigned DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10,
    SIZE_RSVD = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RMW_RD,
    RMW_WR,
    WRITE,
    RESP
  } state_e;

  // Request attributes still needed after the accept edge
  typedef struct packed {
    size_e size;
    logic  sign;
  } req_ctl_t;

  // Reserved size or an offset that does not match the access width
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] offset);
    case (size)
      SIZE_BYTE: return 1'b0;
      SIZE_HALF: return offset[0];
      SIZE_WORD: return offset != 2'b00;
      default:   return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Big-endian lane steering: extracts/extends a load lane and merges a store
// lane into a word (byte offset 0 lives in bits [31:24]).
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic        sign_ext,
  input  logic [15:0] store_data,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [4:0]  shamt;
  logic [31:0] mask;
  logic [31:0] lane;

  always_comb begin
    shamt      = 5'd0;
    mask       = 32'hFFFF_FFFF;
    load_data  = 32'd0;
    // Lane position counts down from the MSB as the offset grows
    case (size)
      SIZE_BYTE: begin
        shamt = {~offset, 3'b000};
        mask  = 32'h0000_00FF;
      end
      SIZE_HALF: begin
        shamt = {~offset[1], 4'b0000};
        mask  = 32'h0000_FFFF;
      end
      default: ;
    endcase
    lane = (word >> shamt) & mask;
    case (size)
      SIZE_BYTE: load_data = {{24{sign_ext & lane[7]}}, lane[7:0]};
      SIZE_HALF: load_data = {{16{sign_ext & lane[15]}}, lane[15:0]};
      default:   load_data = lane;
    endcase
    merge_data = (word & ~(mask << shamt)) | ((32'(store_data) & mask) << shamt);
  end

endmodule

// File: rtl/load_store_unit.sv
// Single-outstanding load/store unit between a processor request port and a
// word-wide big-endian data memory; sub-word stores use read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_e            state, state_nx;
  req_ctl_t          ctl_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] word_q;
  logic [DATA_W-1:0] lane_word;
  logic [DATA_W-1:0] load_data;
  logic [DATA_W-1:0] merge_data;
  logic              accept;
  logic              req_bad;

  assign req_bad   = misaligned(req_size, req_addr[1:0]);
  assign accept    = req_valid && req_ready;
  assign lane_word = (state == RMW_WR) ? word_q : mem_rdata;

  lsu_byte_lane u_lane (
    .word       (lane_word),
    .size       (ctl_q.size),
    .offset     (addr_q[1:0]),
    .sign_ext   (ctl_q.sign),
    .store_data (wdata_q[15:0]),
    .load_data  (load_data),
    .merge_data (merge_data)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state and strobes; everything is forced quiet while rst is high
  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (!rst) begin
      case (state)
        IDLE: begin
          req_ready = 1'b1;
          if (req_valid) begin
            if (req_bad)                   state_nx = RESP;
            else if (!req_write)           state_nx = LOAD;
            else if (req_size == SIZE_WORD) state_nx = WRITE;
            else                           state_nx = RMW_RD;
          end
        end
        LOAD, RMW_RD: begin
          mem_read = 1'b1;
          mem_addr = {addr_q[ADDR_W-1:2], 2'b00};
          state_nx = (state == LOAD) ? RESP : RMW_WR;
        end
        RMW_WR: begin
          mem_write = 1'b1;
          mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
          mem_wdata = merge_data;
          state_nx  = RESP;
        end
        WRITE: begin
          mem_write = 1'b1;
          mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
          mem_wdata = wdata_q;
          state_nx  = RESP;
        end
        RESP: begin
          resp_valid = 1'b1;
          state_nx   = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  // Request capture and response data; results are held until the next RESP
  always_ff @(posedge clk) begin
    if (rst) begin
      ctl_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      word_q     <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      if (accept) begin
        ctl_q   <= '{size: size_e'(req_size), sign: req_signed};
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        if (req_bad) begin
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end
      end
      case (state)
        LOAD: begin
          resp_rdata <= load_data;
          resp_err   <= 1'b0;
        end
        RMW_RD: word_q <= mem_rdata;
        RMW_WR, WRITE: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vectors plus random accesses checked
// against a byte-addressed reference memory.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  int n_checks = 0;
  int n_errors = 0;

  // Memory seen by the DUT (words) and the reference model (bytes)
  logic [31:0] env_mem [16];
  logic [7:0]  ref_mem [64];
  logic        preset_en = 1'b0;
  logic [3:0]  preset_idx = 4'd0;
  logic [31:0] preset_val = 32'd0;

  int both_hi = 0;
  int wdata_leak = 0;
  int rst_leak = 0;

  always #5 clk = ~clk;

  load_store_unit dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = env_mem[mem_addr[5:2]];

  always @(posedge clk) begin
    if (preset_en)      env_mem[preset_idx] <= preset_val;
    else if (mem_write) env_mem[mem_addr[5:2]] <= mem_wdata;
  end

  always @(negedge clk) begin
    if (mem_read && mem_write) both_hi++;
    if (!mem_write && mem_wdata != 32'd0) wdata_leak++;
    if (rst && (mem_read || mem_write || req_ready || resp_valid)) rst_leak++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_word(input int idx, input logic [31:0] val);
    @(negedge clk);
    preset_idx = 4'(idx);
    preset_val = val;
    preset_en  = 1'b1;
    @(posedge clk);
    #1 preset_en = 1'b0;
    for (int b = 0; b < 4; b++) ref_mem[idx*4 + b] = val[31 - 8*b -: 8];
  endtask

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sgn, input logic [5:0] a);
    logic [31:0] v;
    case (sz)
      2'd0: begin
        v = {24'd0, ref_mem[a]};
        if (sgn && v[7]) v = v | 32'hFFFF_FF00;
      end
      2'd1: begin
        v = {16'd0, ref_mem[a], ref_mem[a + 6'd1]};
        if (sgn && v[15]) v = v | 32'hFFFF_0000;
      end
      default: v = {ref_mem[a], ref_mem[a + 6'd1], ref_mem[a + 6'd2], ref_mem[a + 6'd3]};
    endcase
    return v;
  endfunction

  task automatic ref_store(input logic [1:0] sz, input logic [5:0] a, input logic [31:0] wd);
    case (sz)
      2'd0: ref_mem[a] = wd[7:0];
      2'd1: begin
        ref_mem[a]        = wd[15:8];
        ref_mem[a + 6'd1] = wd[7:0];
      end
      default: for (int b = 0; b < 4; b++) ref_mem[a + 6'(b)] = wd[31 - 8*b -: 8];
    endcase
  endtask

  // One complete access: expectations come from the reference model first
  task automatic do_access(input logic wr, input logic [1:0] sz, input logic sgn,
                           input logic [5:0] a, input logic [31:0] wd, input string tag);
    logic        bad;
    logic        got_resp;
    logic [31:0] exp_rd;
    int          exp_lat, exp_rn, exp_wn, rn, wn, abad, lat, guard;
    bad     = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    exp_rd  = 32'd0;
    exp_rn  = 0;
    exp_wn  = 0;
    exp_lat = 1;
    if (!bad) begin
      if (!wr) begin
        exp_rd  = ref_load(sz, sgn, a);
        exp_rn  = 1;
        exp_lat = 2;
      end else if (sz == 2'd2) begin
        exp_wn  = 1;
        exp_lat = 2;
        ref_store(sz, a, wd);
      end else begin
        exp_rn  = 1;
        exp_wn  = 1;
        exp_lat = 3;
        ref_store(sz, a, wd);
      end
    end
    @(negedge clk);
    req_write  = wr;
    req_size   = sz;
    req_signed = sgn;
    req_addr   = {26'd0, a};
    req_wdata  = wd;
    req_valid  = 1'b1;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    check_eq({tag, "_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_wdata = $urandom;
    rn = 0;
    wn = 0;
    abad = 0;
    lat = 0;
    got_resp = 1'b0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        lat = c;
        got_resp = 1'b1;
        break;
      end
      rn += int'(mem_read);
      wn += int'(mem_write);
      if ((mem_read || mem_write) && mem_addr != {26'd0, a[5:2], 2'b00}) abad++;
    end
    if (!got_resp) begin
      check_eq({tag, "_resp_timeout"}, 32'd0, 32'd1);
      return;
    end
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_rdata"}, resp_rdata, exp_rd);
    check_eq({tag, "_err"}, 32'(resp_err), 32'(bad));
    check_eq({tag, "_reads"}, 32'(rn), 32'(exp_rn));
    check_eq({tag, "_writes"}, 32'(wn), 32'(exp_wn));
    check_eq({tag, "_mem_addr"}, 32'(abad), 32'd0);
    @(negedge clk);
    check_eq({tag, "_pulse"}, 32'(resp_valid), 32'd0);
    check_eq({tag, "_hold"}, resp_rdata, exp_rd);
  endtask

  initial begin
    int first_resp, acc2, second_resp, rv_cnt, r;
    logic [1:0] sz;
    logic [5:0] a;

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_rdata", resp_rdata, 32'd0);
    check_eq("rst_err", 32'(resp_err), 32'd0);
    check_eq("rst_mem_addr", mem_addr, 32'd0);
    check_eq("rst_mem_wdata", mem_wdata, 32'd0);
    check_eq("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
    rst = 1'b0;
    #1 check_eq("post_rst_ready", 32'(req_ready), 32'd1);

    for (int i = 0; i < 16; i++) set_word(i, $urandom);

    // Sub-word loads with and without sign extension
    set_word(4, 32'h8899_AABB);
    do_access(1'b0, 2'd0, 1'b1, 6'h11, 32'd0, "lb_11");
    do_access(1'b0, 2'd0, 1'b0, 6'h11, 32'd0, "lbu_11");
    check_eq("lb_11_const", resp_rdata, 32'h0000_0099);

    set_word(4, 32'h8899_AABB);
    do_access(1'b1, 2'd1, 1'b0, 6'h12, 32'h0000_1234, "sh_12");
    check_eq("sh_12_word", env_mem[4], 32'h8899_1234);

    set_word(4, 32'h8899_AABB);
    do_access(1'b1, 2'd2, 1'b0, 6'h10, 32'hDEAD_BEEF, "sw_10");
    do_access(1'b0, 2'd2, 1'b0, 6'h10, 32'd0, "lw_10");
    check_eq("lw_10_const", resp_rdata, 32'hDEAD_BEEF);

    set_word(4, 32'h8899_AABB);
    do_access(1'b0, 2'd1, 1'b0, 6'h13, 32'd0, "lh_13");
    do_access(1'b1, 2'd3, 1'b0, 6'h10, 32'hFFFF_FFFF, "rsvd_st");
    do_access(1'b0, 2'd3, 1'b1, 6'h10, 32'd0, "rsvd_ld");

    // Reset while the read-modify-write is about to write back
    set_word(4, 32'h8899_AABB);
    @(negedge clk);
    req_write  = 1'b1;
    req_size   = 2'd0;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    req_wdata  = 32'h0000_0055;
    req_valid  = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check_eq("abort_rmw_rd", 32'(mem_read), 32'd1);
    @(negedge clk);
    check_eq("abort_rmw_wr", 32'(mem_write), 32'd1);
    rst = 1'b1;
    #1 check_eq("abort_write_gated", 32'(mem_write), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1 check_eq("abort_ready", 32'(req_ready), 32'd1);
    rv_cnt = 0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      rv_cnt += int'(resp_valid);
    end
    check_eq("abort_no_resp", 32'(rv_cnt), 32'd0);
    check_eq("abort_word", env_mem[4], 32'h8899_AABB);

    // Request held valid across RESP is taken in the very next IDLE cycle
    set_word(4, 32'h8899_AABB);
    first_resp = -1;
    acc2 = -1;
    second_resp = -1;
    @(negedge clk);
    req_write  = 1'b0;
    req_size   = 2'd2;
    req_signed = 1'b0;
    req_addr   = 32'h10;
    req_valid  = 1'b1;
    @(posedge clk);
    #1;
    req_size = 2'd0;
    req_addr = 32'h13;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (resp_valid && first_resp < 0) begin
        first_resp = c;
        check_eq("b2b_lw", resp_rdata, 32'h8899_AABB);
      end else if (resp_valid && second_resp < 0) begin
        second_resp = c;
        check_eq("b2b_lbu", resp_rdata, 32'h0000_00BB);
      end
      if (req_ready && req_valid && acc2 < 0) begin
        acc2 = c;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    check_eq("b2b_first_resp", 32'(first_resp), 32'd2);
    check_eq("b2b_second_accept", 32'(acc2), 32'd3);
    check_eq("b2b_second_resp", 32'(second_resp), 32'd5);

    for (int n = 0; n < 200; n++) begin
      r  = $urandom_range(0, 7);
      sz = (r < 3) ? 2'd0 : (r < 5) ? 2'd1 : (r < 7) ? 2'd2 : 2'd3;
      a  = 6'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      do_access(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, "rnd");
    end

    for (int i = 0; i < 16; i++)
      check_eq("final_mem", env_mem[i],
               {ref_mem[4*i], ref_mem[4*i + 1], ref_mem[4*i + 2], ref_mem[4*i + 3]});
    check_eq("read_write_overlap", 32'(both_hi), 32'd0);
    check_eq("wdata_when_idle", 32'(wdata_leak), 32'd0);
    check_eq("activity_in_reset", 32'(rst_leak), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
